seg7_scan: RTL and testbench
============================

# seg7_scan

Time-multiplexed driver for an N-digit, common-anode, active-low 7-segment display. It latches a packed hexadecimal value and per-digit decimal-point, blank and blink masks, then scans the digits one at a time. Each digit slot starts with an anti-ghosting dead time, and the block also provides optional leading-zero suppression and blinking. It sits between the controller-status/debug logic and the board display pins, and generalises the single-digit combinational hex decoder to a registered multi-digit scanner.

## Interface
- N_DIGITS, 4: number of digits scanned, at least 1.
- SLOT_CYCLES, 50000: clock cycles per digit slot, at least DEAD_CYCLES+1.
- DEAD_CYCLES, 500: cycles at the start of each slot with all anodes off, at least 0.
- BLINK_FRAMES, 64: full scan frames per blink half-period, at least 1.

Ports:
- clk  in  1  system clock; the block uses one clock.
- rst  in  1  reset, synchronous and active-high.
- value  in  4*N_DIGITS  hex nibbles; digit i is value[4i+3:4i], and digit 0 is the rightmost.
- dp  in  N_DIGITS  decimal point request per digit, 1 = lit.
- blank  in  N_DIGITS  forced blank per digit, 1 = dark.
- blink  in  N_DIGITS  blink enable per digit.
- lz_en  in  1  enables leading-zero suppression.
- load  in  1  one-cycle strobe that captures value, dp, blank, blink and lz_en.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  out  1  decimal point, active-low.
- an_n  out  N_DIGITS  digit enables, active-low, at most one low at a time.
- frame_tick  out  1  one-cycle pulse when the scan wraps from digit N-1 to digit 0.

## Operation
- Shadow registers:
  - When load=1 at an edge, all five input groups are captured into shadow registers.
  - Display decoding uses only the shadow registers, so the display cannot tear.
  - Inputs are ignored while load=0.
- Slot counter:
  - slot_cnt counts 0..SLOT_CYCLES-1.
  - At SLOT_CYCLES-1 it wraps to 0 and the digit index dig advances by one, wrapping from N_DIGITS-1 to 0.
  - On that wrap, frame_cnt increments.
- Blink phase:
  - frame_cnt counts 0..BLINK_FRAMES-1.
  - On its wrap, blink_ph toggles: 1 = visible, 0 = hidden.
- Digit visibility: digit dig is shown when none of the following holds.
  - slot_cnt < DEAD_CYCLES (dead time).
  - blank[dig] = 1.
  - blink[dig] = 1 and blink_ph = 0.
  - The digit is a suppressed leading zero.
- Leading-zero suppression:
  - Applies only when lz_en = 1.
  - Digit i is suppressed when its nibble and every nibble above it (i..N_DIGITS-1) are 0, and i is not 0.
  - Digit 0 is always shown, so an all-zero value displays a single "0".
  - Forced blank does not affect the zero test.
- Hidden digit: an_n is all 1s, seg_n = 7'b1111111 and dp_n = 1.
- Shown digit:
  - an_n[dig] = 0 and all other anode bits are 1.
  - seg_n is the glyph of nibble dig, and dp_n = ~dp[dig].
- Glyphs (seg_n):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000.
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1011000.
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011.
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110.
- Dead-time exceptions:
  - When DEAD_CYCLES = 0, there is no dead time.
  - When N_DIGITS = 1, dig stays at 0 and the dead time still applies every slot.

## Timing
- Reset values:
  - Internal state: slot_cnt = 0, dig = 0, frame_cnt = 0, blink_ph = 1.
  - Shadow registers all 0, with lz_en = 0.
  - Outputs: seg_n = 7'h7F, dp_n = 1, an_n all 1s, frame_tick = 0.
- Reset mid-scan takes effect at the next edge and restarts the scan at slot 0 of digit 0.
- Output pipeline:
  - All outputs are registered.
  - They reflect the internal state (slot_cnt, dig, shadow, blink_ph) of the previous cycle, a 1-cycle latency.
- Load latency:
  - A load at edge k updates the shadow registers at edge k.
  - The outputs change at edge k+1.
  - A load during a visible slot changes the lit digit mid-slot, which is accepted.
- frame_tick:
  - High for exactly one cycle.
  - Registered on the cycle after the internal wrap from (dig = N_DIGITS-1, slot_cnt = SLOT_CYCLES-1).
- Scan period: one frame takes N_DIGITS*SLOT_CYCLES cycles.
- Blink period: the full period is 2*BLINK_FRAMES frames.
- Simultaneous events:
  - load coinciding with a slot or frame wrap: both take effect at the same edge.
  - rst dominates load.

## Test plan
All scenarios use N_DIGITS=4, SLOT_CYCLES=8, DEAD_CYCLES=2, BLINK_FRAMES=2.

1. Reset held 3 cycles, then released with no load -> outputs are 7F / 1 / 1111 during reset. After release, all four digits show "0" (seg_n=1000000) with an_n = 1110, 1101, 1011, 0111 in turn. Each anode is low for 6 output cycles, preceded by 2 all-off cycles.
2. load with value=16'h12AF and dp=4'b0100 -> the slots of digits 0..3 show F=0001110, A=0001000, 2=0100100, 1=1111001. dp_n=0 only while an_n=1011, and outputs change on the cycle after load.
3. lz_en=1: value=16'h0030 shows digits 1 and 0 only, with an_n never 0111 or 1011. value=16'h0000 shows only digit 0 as "0". value=16'h0100 shows digits 2..0.
4. blink=4'b0001 with value 16'h5555 -> digit 0 is dark for frames 2,3, lit for frames 4,5, and so on. frame_tick pulses every 32 cycles, and digits 1-3 stay lit throughout.
5. rst asserted at dig=2, slot_cnt=5 -> outputs go 7F / 1111 on the next cycle. After release the scan resumes at digit 0 with the shadow cleared, and blank=4'b1111 with load keeps an_n at 1111 permanently.

Source files
------------

// File: rtl/seg7_scan.sv
// Multi-digit, common-anode, active-low 7-segment scanner with shadowed inputs,
// per-slot anti-ghosting dead time, leading-zero suppression and blinking.
module seg7_scan #(
  parameter int N_DIGITS     = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int DEAD_CYCLES  = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   blank,
  input  logic [N_DIGITS-1:0]   blink,
  input  logic                  lz_en,
  input  logic                  load,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [N_DIGITS-1:0]   an_n,
  output logic                  frame_tick
);

  localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT_CYCLES - 1);
  localparam logic [DW-1:0] DIG_LAST   = DW'(N_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic [DW-1:0] dig_q, dig_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_ph_q, blink_ph_d;

  logic [4*N_DIGITS-1:0] val_sh_q;
  logic [N_DIGITS-1:0]   dp_sh_q, blank_sh_q, blink_sh_q;
  logic                  lz_sh_q;

  logic [6:0]          seg_n_q, seg_n_d;
  logic                dp_n_q, dp_n_d;
  logic [N_DIGITS-1:0] an_n_q, an_n_d;
  logic                tick_q, tick_d;

  logic                slot_wrap, frame_wrap;
  logic [3:0]          nib;
  logic                zero_above, in_dead, show;
  logic [N_DIGITS-1:0] lz_sup;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1011000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // Scan timing: slot counter, digit index, frame counter and blink phase
  always_comb begin
    slot_wrap   = (slot_cnt_q == SLOT_LAST);
    frame_wrap  = slot_wrap && (dig_q == DIG_LAST);
    slot_cnt_d  = slot_wrap ? '0 : slot_cnt_q + 1'b1;
    dig_d       = dig_q;
    frame_cnt_d = frame_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (slot_wrap) begin
      dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
    end
    if (frame_wrap) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Decode from shadow state; the result is registered one cycle later
  always_comb begin
    nib        = val_sh_q[4*dig_q +: 4];
    zero_above = 1'b1;
    lz_sup     = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (val_sh_q[4*i +: 4] == 4'h0);
      lz_sup[i]  = lz_sh_q && zero_above && (i != 0);
    end
    in_dead = (DEAD_CYCLES > 0) && (32'(slot_cnt_q) < 32'(DEAD_CYCLES));
    show    = !in_dead && !blank_sh_q[dig_q] && !(blink_sh_q[dig_q] && !blink_ph_q)
              && !lz_sup[dig_q];
    seg_n_d = 7'h7F;
    dp_n_d  = 1'b1;
    an_n_d  = '1;
    if (show) begin
      seg_n_d       = glyph(nib);
      dp_n_d        = ~dp_sh_q[dig_q];
      an_n_d[dig_q] = 1'b0;
    end
    tick_d = frame_wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q  <= '0;
      dig_q       <= '0;
      frame_cnt_q <= '0;
      blink_ph_q  <= 1'b1;
      val_sh_q    <= '0;
      dp_sh_q     <= '0;
      blank_sh_q  <= '0;
      blink_sh_q  <= '0;
      lz_sh_q     <= 1'b0;
      seg_n_q     <= 7'h7F;
      dp_n_q      <= 1'b1;
      an_n_q      <= '1;
      tick_q      <= 1'b0;
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      dig_q       <= dig_d;
      frame_cnt_q <= frame_cnt_d;
      blink_ph_q  <= blink_ph_d;
      if (load) begin
        val_sh_q   <= value;
        dp_sh_q    <= dp;
        blank_sh_q <= blank;
        blink_sh_q <= blink;
        lz_sh_q    <= lz_en;
      end
      seg_n_q <= seg_n_d;
      dp_n_q  <= dp_n_d;
      an_n_q  <= an_n_d;
      tick_q  <= tick_d;
    end
  end

  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign an_n       = an_n_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: table of display settings with hand-derived glyphs and
// visibility, expectations queued per driven cycle and compared after each edge.
module tb_seg7_scan;
  localparam int N = 4, SLOT = 8, DEAD = 2, BF = 2;
  localparam int FRAME = N * SLOT;

  logic         clk = 1'b0;
  logic         rst, lz_en, load;
  logic [15:0]  value;
  logic [3:0]   dp, blank, blink;
  logic [6:0]   seg_n;
  logic         dp_n, frame_tick;
  logic [3:0]   an_n;

  seg7_scan #(.N_DIGITS(N), .SLOT_CYCLES(SLOT), .DEAD_CYCLES(DEAD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .blank(blank), .blink(blink),
    .lz_en(lz_en), .load(load), .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dp, blank, blink;
    logic            lz;
    logic [3:0][6:0] seg;   // expected glyph per digit, [3] first in literals
    logic [3:0]      vis;   // digit shown, ignoring dead time and blink phase
  } vec_t;

  typedef struct packed {
    logic [6:0] seg;
    logic       dpn;
    logic [3:0] an;
    logic       tick;
  } exp_t;

  vec_t vecs[11];
  vec_t cur;
  exp_t sb[$];
  int   t;
  int   checks = 0;
  int   errors = 0;

  task automatic cycle(input logic do_load, input int vi, input logic r);
    exp_t e, got;
    int   s, d, f;
    logic shw;
    rst  = r;
    load = do_load;
    if (do_load) begin
      value = vecs[vi].value;
      dp    = vecs[vi].dp;
      blank = vecs[vi].blank;
      blink = vecs[vi].blink;
      lz_en = vecs[vi].lz;
    end
    if (r) begin
      e = '{seg: 7'h7F, dpn: 1'b1, an: 4'hF, tick: 1'b0};
    end else begin
      s   = t % SLOT;
      d   = (t / SLOT) % N;
      f   = t / FRAME;
      shw = (s >= DEAD) && cur.vis[d] && !(cur.blink[d] && ((f / BF) % 2 == 1));
      e.seg  = shw ? cur.seg[d] : 7'h7F;
      e.dpn  = shw ? ~cur.dp[d] : 1'b1;
      e.an   = shw ? ~(4'b0001 << d) : 4'hF;
      e.tick = ((t % FRAME) == FRAME - 1);
    end
    sb.push_back(e);
    if (r) begin
      cur = vecs[0];
      t   = 0;
    end else begin
      if (do_load) cur = vecs[vi];
      t++;
    end
    @(posedge clk);
    #1;
    load = 1'b0;
    got = '{seg: seg_n, dpn: dp_n, an: an_n, tick: frame_tick};
    e   = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL out t=%0d: got seg=%b dp_n=%b an=%b tick=%b, want seg=%b dp_n=%b an=%b tick=%b",
               t, got.seg, got.dpn, got.an, got.tick, e.seg, e.dpn, e.an, e.tick);
    end
  endtask

  initial begin
    vecs[0]  = '{16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b0,
                 {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b1111};
    vecs[1]  = '{16'h12AF, 4'b0100, 4'b0000, 4'b0000, 1'b0,
                 {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'b1111};
    vecs[2]  = '{16'h0030, 4'b0000, 4'b0000, 4'b0000, 1'b1,
                 {7'b1111111, 7'b1111111, 7'b0110000, 7'b1000000}, 4'b0011};
    vecs[3]  = '{16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b1,
                 {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b0001};
    vecs[4]  = '{16'h0100, 4'b0000, 4'b0000, 4'b0000, 1'b1,
                 {7'b1111111, 7'b1111001, 7'b1000000, 7'b1000000}, 4'b0111};
    vecs[5]  = '{16'h5555, 4'b0000, 4'b0000, 4'b0001, 1'b0,
                 {7'b0010010, 7'b0010010, 7'b0010010, 7'b0010010}, 4'b1111};
    vecs[6]  = '{16'h8888, 4'b1111, 4'b1111, 4'b0000, 1'b0,
                 {7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000}, 4'b0000};
    vecs[7]  = '{16'h0800, 4'b0001, 4'b0100, 4'b0000, 1'b1,
                 {7'b1111111, 7'b0000000, 7'b1000000, 7'b1000000}, 4'b0011};
    vecs[8]  = '{16'hC9E4, 4'b1001, 4'b0000, 4'b0000, 1'b0,
                 {7'b1000110, 7'b0010000, 7'b0000110, 7'b0011001}, 4'b1111};
    vecs[9]  = '{16'hD876, 4'b0000, 4'b0000, 4'b0000, 1'b1,
                 {7'b0100001, 7'b0000000, 7'b1011000, 7'b0000010}, 4'b1111};
    vecs[10] = '{16'h3B5A, 4'b0010, 4'b0000, 4'b1010, 1'b0,
                 {7'b0110000, 7'b0000011, 7'b0010010, 7'b0001000}, 4'b1111};

    rst = 1'b1; load = 1'b0; lz_en = 1'b0;
    value = '0; dp = '0; blank = '0; blink = '0;
    cur = vecs[0];
    t   = 0;

    repeat (3) cycle(1'b0, 0, 1'b1);
    repeat (40) cycle(1'b0, 0, 1'b0);

    // Each setting runs past two blink half-periods; inputs are scrambled after
    // the load so that only the shadowed copy can drive the display.
    for (int v = 1; v < 11; v++) begin
      cycle(1'b1, v, 1'b0);
      value = 16'($urandom);
      dp    = 4'($urandom);
      blank = 4'($urandom);
      blink = 4'($urandom);
      lz_en = 1'($urandom);
      repeat (130) cycle(1'b0, 0, 1'b0);
    end

    // Reset landing on digit 2, slot 5, with a competing load
    for (int k = 0; k < 2 * FRAME && (t % FRAME) != 2 * SLOT + 5; k++) cycle(1'b0, 0, 1'b0);
    cycle(1'b1, 1, 1'b1);
    repeat (40) cycle(1'b0, 0, 1'b0);

    // Fully blanked display stays dark across frames and blink phases
    cycle(1'b1, 6, 1'b0);
    repeat (140) cycle(1'b0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
